// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - memory-mapped 32-bit down-counting timer with one-shot and auto-reload modes
module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        ctrl_en;
    logic [1:0]  ctrl_mode;
    logic        ctrl_im;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;

    logic        wr_ctrl;
    logic        wr_preset;
    logic        auto_reload;
    logic        count_zero;

    logic        load_count;
    logic        dec_count;
    logic        set_flag;
    logic        int_clr_en;
    logic        int_clr_flag;

    assign wr_ctrl     = we && (addr[3:2] == 2'd0);
    assign wr_preset   = we && (addr[3:2] == 2'd1);
    assign auto_reload = (ctrl_mode == 2'b01);
    assign count_zero  = (count == 32'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (ctrl_en) state_nxt = S_LOAD;
            S_LOAD: state_nxt = S_CNT;
            S_CNT: begin
                if (!ctrl_en) begin
                    state_nxt = S_IDLE;
                end else if (count_zero) begin
                    state_nxt = S_INT;
                end
            end
            S_INT:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // The counter stops at zero inside CNT, so the decrement can never wrap.
    always_comb begin
        load_count   = (state == S_LOAD);
        dec_count    = (state == S_CNT) && ctrl_en && !count_zero;
        set_flag     = (state == S_CNT) && ctrl_en && count_zero;
        int_clr_en   = (state == S_INT) && !auto_reload;
        int_clr_flag = (state == S_INT) && auto_reload;
    end

    // Bus writes take precedence over the FSM's own updates of EN and irq_flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_en   <= 1'b0;
            ctrl_mode <= 2'b00;
            ctrl_im   <= 1'b0;
            preset    <= 32'd0;
            count     <= 32'd0;
            irq_flag  <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                {ctrl_im, ctrl_mode, ctrl_en} <= wdata[3:0];
            end else if (int_clr_en) begin
                ctrl_en <= 1'b0;
            end

            if (wr_preset) begin
                preset <= wdata;
            end

            if (load_count) begin
                count <= preset;
            end else if (dec_count) begin
                count <= count - 32'd1;
            end

            if (wr_ctrl || wr_preset) begin
                irq_flag <= 1'b0;
            end else if (set_flag) begin
                irq_flag <= 1'b1;
            end else if (int_clr_flag) begin
                irq_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (addr[3:2])
            2'd0:    rdata = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
            2'd1:    rdata = preset;
            2'd2:    rdata = count;
            default: rdata = 32'd0;
        endcase
    end

    assign irq = irq_flag & ctrl_im;

endmodule

// File: tb/tb_timer_counter.sv
// tb/tb_timer_counter.sv - directed self-checking bench for timer_counter
module tb_timer_counter;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int n_vec;
    int n_err;

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we    = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        #1;
        n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got=%b exp=0", irq); end
        for (int i = 0; i < 4; i++) begin
            bus_read(32'(i * 4), rd);
            n_vec++;
            if (rd !== 32'd0) begin n_err++; $display("FAIL reset_reg%0d got=%h exp=0", i, rd); end
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus_read(32'h8, rd);
        n_vec++;
        if (rd !== 32'd0) begin n_err++; $display("FAIL reset_idle_count got=%h exp=0", rd); end
    endtask

    task automatic test_one_shot;
        logic [31:0] rd;
        bus_write(32'h4, 32'd5);
        bus_write(32'h0, 32'h9);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (irq !== (k >= 8)) begin n_err++; $display("FAIL oneshot_irq_e%0d got=%b exp=%b", k, irq, (k >= 8)); end
            if (k == 2) begin
                bus_read(32'h8, rd);
                n_vec++;
                if (rd !== 32'd5) begin n_err++; $display("FAIL oneshot_load got=%0d exp=5", rd); end
            end
        end
        bus_read(32'h0, rd);
        n_vec++;
        if (rd !== 32'h8) begin n_err++; $display("FAIL oneshot_ctrl got=%h exp=8", rd); end
        bus_write(32'h0, 32'h8);
        n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL oneshot_clear got=%b exp=0", irq); end
        bus_write(32'h0, 32'h0);
    endtask

    task automatic test_auto_reload;
        logic [31:0] rd;
        logic        exp_irq;
        bus_write(32'h4, 32'd3);
        bus_write(32'h0, 32'hB);
        for (int k = 1; k <= 21; k++) begin
            @(posedge clk);
            #1;
            exp_irq = (k >= 6) && (((k - 6) % 7) == 0);
            n_vec++;
            if (irq !== exp_irq) begin n_err++; $display("FAIL reload_irq_e%0d got=%b exp=%b", k, irq, exp_irq); end
            if (k == 2 || k == 9 || k == 16) begin
                bus_read(32'h8, rd);
                n_vec++;
                if (rd !== 32'd3) begin n_err++; $display("FAIL reload_count_e%0d got=%0d exp=3", k, rd); end
            end
        end
        bus_write(32'h0, 32'h0);
        repeat (3) @(posedge clk);
    endtask

    task automatic test_mask_pause;
        logic [31:0] rd;
        bus_write(32'h4, 32'd2);
        bus_write(32'h0, 32'h1);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (irq !== 1'b0) begin n_err++; $display("FAIL mask_irq_e%0d got=%b exp=0", k, irq); end
        end
        bus_write(32'h0, 32'h9);
        n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL mask_unmask got=%b exp=0", irq); end
        bus_write(32'h0, 32'h0);
        repeat (4) @(posedge clk);

        bus_write(32'h4, 32'd10);
        bus_write(32'h0, 32'h1);
        repeat (7) @(posedge clk);
        bus_write(32'h0, 32'h0);
        repeat (5) @(posedge clk);
        #1;
        bus_read(32'h8, rd);
        n_vec++;
        if (rd !== 32'd4) begin n_err++; $display("FAIL pause_hold got=%0d exp=4", rd); end
    endtask

    task automatic test_bus_edges;
        logic [31:0] rd;
        bus_write(32'h8, 32'h1234);
        bus_read(32'h8, rd);
        n_vec++;
        if (rd !== 32'd4) begin n_err++; $display("FAIL count_write_ignored got=%h exp=4", rd); end
        bus_write(32'hC, 32'hFFFF_FFFF);
        bus_read(32'hC, rd);
        n_vec++;
        if (rd !== 32'd0) begin n_err++; $display("FAIL unused_slot got=%h exp=0", rd); end
        bus_write(32'h1000_0004, 32'hDEAD_BEEF);
        bus_read(32'h4, rd);
        n_vec++;
        if (rd !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL preset_rw got=%h exp=deadbeef", rd); end
        bus_write(32'h0, 32'hFFFF_FFF8);
        bus_read(32'h0, rd);
        n_vec++;
        if (rd !== 32'h8) begin n_err++; $display("FAIL ctrl_upper got=%h exp=8", rd); end
        bus_write(32'h0, 32'h0);

        bus_write(32'h4, 32'd6);
        bus_write(32'h0, 32'hB);
        repeat (3) @(posedge clk);
        #1;
        bus_read(32'h8, rd);
        n_vec++;
        if (rd !== 32'd5) begin n_err++; $display("FAIL preset_cnt_e3 got=%0d exp=5", rd); end
        bus_write(32'h4, 32'd2);
        @(posedge clk);
        #1;
        bus_read(32'h8, rd);
        n_vec++;
        if (rd !== 32'd3) begin n_err++; $display("FAIL preset_cnt_e5 got=%0d exp=3", rd); end
        repeat (4) @(posedge clk);
        #1;
        n_vec++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL preset_irq_e9 got=%b exp=1", irq); end
        repeat (3) @(posedge clk);
        #1;
        bus_read(32'h8, rd);
        n_vec++;
        if (rd !== 32'd2) begin n_err++; $display("FAIL preset_reload got=%0d exp=2", rd); end
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL preset_irq_e15 got=%b exp=1", irq); end
        bus_write(32'h0, 32'h0);
        repeat (4) @(posedge clk);
    endtask

    task automatic test_collision;
        logic [31:0] rd;
        bus_write(32'h4, 32'd2);
        bus_write(32'h0, 32'h9);
        repeat (5) @(posedge clk);
        #1;
        n_vec++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL coll_irq_int got=%b exp=1", irq); end
        bus_write(32'h0, 32'h9);
        n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL coll_irq_cleared got=%b exp=0", irq); end
        bus_read(32'h0, rd);
        n_vec++;
        if (rd !== 32'h9) begin n_err++; $display("FAIL coll_ctrl got=%h exp=9", rd); end
        bus_write(32'h0, 32'h0);
        repeat (4) @(posedge clk);
    endtask

    task automatic test_reset_mid_count;
        logic [31:0] rd;
        bus_write(32'h4, 32'd0);
        bus_write(32'h0, 32'h9);
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL rst_pre_irq got=%b exp=1", irq); end
        #1;
        reset = 1'b0;
        #1;
        n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL rst_async_irq got=%b exp=0", irq); end
        @(negedge clk);
        reset = 1'b1;

        bus_write(32'h4, 32'd10);
        bus_write(32'h0, 32'h9);
        repeat (5) @(posedge clk);
        #1;
        bus_read(32'h8, rd);
        n_vec++;
        if (rd !== 32'd7) begin n_err++; $display("FAIL rst_mid_count got=%0d exp=7", rd); end
        reset = 1'b0;
        #1;
        n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL rst_mid_irq got=%b exp=0", irq); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            bus_read(32'(i * 4), rd);
            n_vec++;
            if (rd !== 32'd0) begin n_err++; $display("FAIL rst_release_reg%0d got=%h exp=0", i, rd); end
        end
        bus_write(32'h4, 32'd5);
        repeat (10) @(posedge clk);
        #1;
        bus_read(32'h8, rd);
        n_vec++;
        if (rd !== 32'd0) begin n_err++; $display("FAIL rst_no_restart got=%0d exp=0", rd); end
        n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL rst_idle_irq got=%b exp=0", irq); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        we    = 1'b0;
        addr  = 32'd0;
        wdata = 32'd0;
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_mask_pause();
        test_bus_edges();
        test_collision();
        test_reset_mid_count();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/timer_counter.md
# timer_counter

Memory-mapped 32-bit down-counting timer on the CPU data bus, downstream of the pipeline's M-stage store/load port (m_data_addr / m_data_wdata / m_data_rdata), reached through the system bridge. It is the main source of the HWInt bit that the M stage's CP0 samples to raise IntReq. It supports one-shot mode (interrupt held) and auto-reload mode (one-cycle interrupt pulse) under a four-state control FSM.

## Interface
Parameters:
- none; register width is fixed at 32 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; asserting it clears every register and forces state IDLE immediately.
- addr  input  32  byte address from the bridge; only addr[3:2] decoded. 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = unused.
- we  input  1  write strobe, already qualified by the bridge's address decode and full-word byteen.
- wdata  input  32  write data.
- rdata  output  32  combinational read of the selected register; unused slot reads 0.
- irq  output  1  interrupt request to HWInt; irq = irq_flag & CTRL[3].

## Operation
- CTRL bits:
  - [0] EN
  - [2:1] MODE: 00 one-shot; 01 auto-reload; 10 and 11 behave as 00.
  - [3] IM, interrupt mask.
  - [31:4] are not stored and read 0.
- PRESET is fully writable. COUNT is read-only; writes to it are ignored.
- Reset values: CTRL = 0, PRESET = 0, COUNT = 0, irq_flag = 0, state = IDLE, rdata follows addr (0 for every register), irq = 0.
- Bus writes commit on the clock edge. A write to CTRL or PRESET also clears irq_flag on that edge.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN, go to LOAD; otherwise stay. COUNT holds.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - if !EN, go to IDLE and COUNT holds;
    - else if COUNT == 0, go to INT and set irq_flag;
    - else COUNT <= COUNT - 1.
  - INT, one-shot: EN <= 0; go to IDLE; irq_flag stays set.
  - INT, auto-reload: irq_flag <= 0; go to IDLE. EN is still 1, so the counter reloads.
- Decrement is unsigned and never wraps below 0.
- A PRESET write during CNT does not affect the running COUNT. It applies at the next LOAD.
- Simultaneous events:
  - A CTRL write on the same edge as INT's EN clear: the bus write wins, and the CTRL value equals wdata[3:0].
  - A CTRL/PRESET write on the same edge that CNT sets irq_flag: the clear wins, and irq_flag = 0.
  - FSM decisions use the register values from before the edge, so a CTRL write is seen by the FSM one cycle later.

## Timing
- Let E0 be the edge committing CTRL = {IM, MODE, EN = 1} with PRESET = N.
  - E1: IDLE -> LOAD.
  - E2: COUNT = N, state CNT.
  - E3 .. E(N+2): COUNT decrements to 0.
  - E(N+3): INT; irq_flag = 1, and irq rises if IM = 1.
- One-shot mode: at E(N+4) the state returns to IDLE with EN = 0. irq stays high until a CTRL/PRESET write or reset.
- Auto-reload mode: irq is high for exactly one cycle, from E(N+3) to E(N+4). The period is N + 4 cycles: IDLE, LOAD, N + 1 CNT cycles, INT.
- PRESET = 0: INT is reached at E3.
- rdata has zero latency. A read in the cycle after a write returns the new value.
- Reset mid-count: irq drops combinationally with reset, independent of clk. After release the block is fully idle, and the FSM needs a new EN write to restart.

## Test plan
- Reset: drive reset = 0 mid-CNT with COUNT = 7 -> irq = 0 immediately; reads of CTRL, PRESET, COUNT all return 0 after release; state stays idle with no counting.
- One-shot: PRESET = 5, CTRL = 0x9 -> irq rises 8 edges after the write edge, stays high, CTRL reads 0x8. A subsequent CTRL write of 0x8 -> irq = 0.
- Auto-reload: PRESET = 3, CTRL = 0xB -> irq is a one-cycle pulse every 7 cycles for at least 3 periods; COUNT reloads to 3 after each pulse.
- Masking and pause:
  - CTRL = 0x1, PRESET = 2 -> irq stays 0, but a later CTRL write of 0x9 is needed to see the flag (the write clears it, so expect 0).
  - Pause by writing CTRL = 0x0 at COUNT = 4 -> COUNT holds 4.
- Bus edge cases:
  - Write to COUNT -> ignored.
  - Read addr[3:2] = 3 -> 0.
  - PRESET write during CNT -> current countdown unchanged, next reload uses the new value.
  - CTRL bits [31:4] read 0.
- Collision: CTRL write 0x9 on the same edge as one-shot INT -> EN remains 1 and irq_flag is cleared.
